mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter MEM_DEPTH, default 256; data memory depth in 32-bit words, power of two.
REQ-002 Parameter WAIT_CYCLES, default 2; extra access cycles per load/store when MEM_WAIT_STATES_EN is defined; minimum 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wb_ctl  input  2  EX/MEM writeback control: bit1 = regwrite, bit0 = memtoreg.
REQ-006 branch, memread, memwrite  input  1 each  EX/MEM memory-stage control.
REQ-007 zero  input  1  ALU zero flag from EX/MEM.
REQ-008 alu_result  input  32  ALU result; byte address for loads and stores.
REQ-009 rdata2  input  32  store data.
REQ-010 five_bit_muxout  input  5  destination register number.
REQ-011 EX_MEM_PCSrc  output  1  branch-taken select to fetch.
REQ-012 MEM_WB_regwrite, MEM_WB_memtoreg  output  1 each  registered writeback control.
REQ-013 MEM_WB_rd  output  5  registered destination register.
REQ-014 MEM_WB_readdata, MEM_WB_aluresult  output  32 each  registered load data and ALU result.
REQ-015 WB_mux_writedata  output  32  writeback data to decode.
REQ-016 mem_stall  output  1  high while a multi-cycle access is in progress; upstream holds its inputs.

Function
REQ-017 EX_MEM_PCSrc SHALL equal branch AND zero, combinationally, with no latency.
REQ-018 The word index SHALL be alu_result[log2(MEM_DEPTH)+1:2]; bits [1:0] are ignored; higher bits wrap modulo MEM_DEPTH.
REQ-019 A store SHALL write rdata2 to the indexed word on the completing edge of the access.
REQ-020 A load SHALL capture the indexed word into MEM_WB_readdata on the completing edge of the access.
REQ-021 When memread and memwrite are both asserted, the write SHALL win and MEM_WB_readdata SHALL load 0.
REQ-022 When memread and memwrite are both low, MEM_WB_readdata SHALL load 0.
REQ-023 On every non-stalled edge, the MEM/WB register SHALL load wb_ctl, five_bit_muxout, alu_result and the read data; latency is one cycle.
REQ-024 WB_mux_writedata SHALL be MEM_WB_readdata when MEM_WB_memtoreg=1, else MEM_WB_aluresult, combinationally.
REQ-025 On each stalled edge, the MEM/WB register SHALL load a bubble: regwrite=0, memtoreg=0, rd=0, data fields 0.

Reset
REQ-026 Asserting rst SHALL immediately clear all MEM/WB outputs to 0, drive mem_stall to 0 and return the FSM to IDLE.
REQ-027 A store pending mid-wait at reset SHALL be discarded; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro MEM_WAIT_STATES_EN, when undefined: every access completes in one cycle, mem_stall is tied to 0, and no FSM exists.
REQ-029 With MEM_WAIT_STATES_EN defined, a 2-state FSM (IDLE, WAIT) with a wait counter SHALL operate as follows.
- IDLE: when memread or memwrite is seen, go to WAIT, load counter = WAIT_CYCLES, assert mem_stall.
- WAIT: decrement the counter each cycle.
- On count 1: perform the access (REQ-019/020), deassert mem_stall and return to IDLE; this is the completing edge.
- A load/store therefore occupies WAIT_CYCLES+1 cycles.
- Back-to-back accesses re-enter WAIT after one IDLE cycle.

Structure
REQ-030 The shared package SHALL hold wb_ctl bit positions, FSM state encodings and the MEM_DEPTH default.
REQ-031 The storage array SHALL be a sub-module named data_memory (one synchronous write port, one read port); the FSM and MEM/WB register stay in mem_access.

Verification
REQ-032 Store then load: store rdata2=0xDEADBEEF at alu_result=0x10, then load 0x10 with memtoreg=1 -> WB_mux_writedata=0xDEADBEEF one cycle after the load.
REQ-033 Branch: branch=1, zero=1 -> EX_MEM_PCSrc=1 in the same cycle; branch=1, zero=0 -> 0.
REQ-034 Wrap: store 0x5 at alu_result=0x400 (MEM_DEPTH=256), load 0x0 -> read data 0x5.
REQ-035 Conflict: memread=memwrite=1, rdata2=0x7, alu_result=0x20 -> MEM_WB_readdata=0; a later load of 0x20 returns 0x7.
REQ-036 MEM_WAIT_STATES_EN, WAIT_CYCLES=2, load -> mem_stall high for 2 cycles, bubbles for 2 cycles, data on the 3rd edge.
REQ-037 Reset mid-WAIT during a store of 0x9 to 0x30 -> outputs 0 immediately, and word 0x30 is unchanged.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: writeback-control bit positions,
// wait-state FSM encodings and the default data-memory depth.
package mem_access_pkg;

    localparam int MEM_DEPTH_DEFAULT = 256;

    localparam int WB_REGWRITE_BIT = 1;
    localparam int WB_MEMTOREG_BIT = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: one synchronous write port, one combinational
// read port. Contents are deliberately not touched by reset.
module data_memory
    import mem_access_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [31:0]              wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: data memory access, branch select and MEM/WB register.
// Defining MEM_WAIT_STATES_EN adds a multi-cycle access FSM with mem_stall.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int MEM_DEPTH   = MEM_DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctl,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    input  logic [4:0]  five_bit_muxout,
    output logic        EX_MEM_PCSrc,
    output logic        MEM_WB_regwrite,
    output logic        MEM_WB_memtoreg,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] MEM_WB_readdata,
    output logic [31:0] MEM_WB_aluresult,
    output logic [31:0] WB_mux_writedata,
    output logic        mem_stall
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [AW-1:0] word_idx;
    logic [31:0]   mem_rdata;
    logic          mem_we;
    logic          complete;
    logic          bubble;
    logic [31:0]   readdata_d;

    logic          regwrite_q;
    logic          memtoreg_q;
    logic [4:0]    rd_q;
    logic [31:0]   readdata_q;
    logic [31:0]   aluresult_q;

    // Upper address bits fall outside the slice, so addresses wrap modulo depth.
    assign word_idx     = alu_result[AW+1:2];
    assign EX_MEM_PCSrc = branch & zero;

`ifdef MEM_WAIT_STATES_EN
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          stall_q;
    logic          access;

    assign access   = memread | memwrite;
    assign complete = (state_q == ST_WAIT) && (cnt_q == CW'(1));
    // Every edge of an access except the completing one leaves a bubble.
    assign bubble   = (state_q == ST_IDLE) ? access : !complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CW'(WAIT_CYCLES);
                        stall_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (complete) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        stall_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_stall = stall_q;
`else
    logic unused_cfg;

    assign complete   = 1'b1;
    assign bubble     = 1'b0;
    assign mem_stall  = 1'b0;
    assign unused_cfg = &{1'b0, WAIT_CYCLES[0]};
`endif

    // A simultaneous read and write resolves to the write; read data is then 0.
    assign mem_we     = memwrite & complete;
    assign readdata_d = (memread && !memwrite) ? mem_rdata : 32'h0;

    data_memory #(
        .DEPTH (MEM_DEPTH)
    ) u_data_memory (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (word_idx),
        .wdata_i (rdata2),
        .raddr_i (word_idx),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            rd_q        <= '0;
            readdata_q  <= '0;
            aluresult_q <= '0;
        end else if (bubble) begin
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            rd_q        <= '0;
            readdata_q  <= '0;
            aluresult_q <= '0;
        end else begin
            regwrite_q  <= wb_ctl[WB_REGWRITE_BIT];
            memtoreg_q  <= wb_ctl[WB_MEMTOREG_BIT];
            rd_q        <= five_bit_muxout;
            readdata_q  <= readdata_d;
            aluresult_q <= alu_result;
        end
    end

    assign MEM_WB_regwrite  = regwrite_q;
    assign MEM_WB_memtoreg  = memtoreg_q;
    assign MEM_WB_rd        = rd_q;
    assign MEM_WB_readdata  = readdata_q;
    assign MEM_WB_aluresult = aluresult_q;
    assign WB_mux_writedata = memtoreg_q ? readdata_q : aluresult_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: vector table through a scoreboard,
// plus branch, reset and address-wrap sequences. Honours MEM_WAIT_STATES_EN.
module tb_mem_access;

    localparam int WC = 2;
    localparam int W  = 71;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] alu;
    } wb_t;

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [1:0]  wb;
        logic [4:0]  rdn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [1:0]  wb_ctl;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2;
    logic [4:0]  five_bit_muxout;
    logic        EX_MEM_PCSrc;
    logic        MEM_WB_regwrite;
    logic        MEM_WB_memtoreg;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_readdata;
    logic [31:0] MEM_WB_aluresult;
    logic [31:0] WB_mux_writedata;
    logic        mem_stall;

    logic [W-1:0] exp_q[$];
    int tests_run;
    int tests_failed;

    mem_access #(
        .MEM_DEPTH   (256),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wb_ctl           (wb_ctl),
        .branch           (branch),
        .memread          (memread),
        .memwrite         (memwrite),
        .zero             (zero),
        .alu_result       (alu_result),
        .rdata2           (rdata2),
        .five_bit_muxout  (five_bit_muxout),
        .EX_MEM_PCSrc     (EX_MEM_PCSrc),
        .MEM_WB_regwrite  (MEM_WB_regwrite),
        .MEM_WB_memtoreg  (MEM_WB_memtoreg),
        .MEM_WB_rd        (MEM_WB_rd),
        .MEM_WB_readdata  (MEM_WB_readdata),
        .MEM_WB_aluresult (MEM_WB_aluresult),
        .WB_mux_writedata (WB_mux_writedata),
        .mem_stall        (mem_stall)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog timeout");
    end

    function automatic logic [W-1:0] wb_now();
        return {MEM_WB_regwrite, MEM_WB_memtoreg, MEM_WB_rd, MEM_WB_readdata, MEM_WB_aluresult};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one access, push its expected MEM/WB contents, compare on completion.
    task automatic access(input logic rd_en, input logic wr_en, input logic [1:0] wb,
                          input logic [4:0] rdn, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input string name);
        wb_t e;
        memread         = rd_en;
        memwrite        = wr_en;
        wb_ctl          = wb;
        five_bit_muxout = rdn;
        alu_result      = addr;
        rdata2          = wdata;
        exp_q.push_back({wb[1], wb[0], rdn, exp_rdata, addr});
`ifdef MEM_WAIT_STATES_EN
        if (rd_en || wr_en) begin
            for (int k = 0; k < WC; k++) begin
                @(posedge clk);
                #1;
                check($sformatf("%s_stall%0d", name, k), W'(mem_stall), W'(1));
                check($sformatf("%s_bubble%0d", name, k), wb_now(), '0);
            end
        end
`endif
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(name, wb_now(), e);
        check($sformatf("%s_wbmux", name), W'(WB_mux_writedata), W'(e.mtr ? e.rdata : e.alu));
        check($sformatf("%s_nostall", name), W'(mem_stall), '0);
    endtask

    vec_t        vecs[12];
    logic [2:0]  br_tab[4];

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst             = 1'b0;
        wb_ctl          = 2'b00;
        branch          = 1'b0;
        memread         = 1'b0;
        memwrite        = 1'b0;
        zero            = 1'b0;
        alu_result      = 32'h0;
        rdata2          = 32'h0;
        five_bit_muxout = 5'd0;

        //           rd    wr    wb     rd     addr        wdata          exp_rdata
        vecs[0]  = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h10,     32'hDEADBEEF,  32'h0};
        vecs[1]  = '{1'b1, 1'b0, 2'b11, 5'd5,  32'h10,     32'h0,         32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h400,    32'h5,         32'h0};
        vecs[3]  = '{1'b1, 1'b0, 2'b11, 5'd3,  32'h0,      32'h0,         32'h5};
        vecs[4]  = '{1'b1, 1'b1, 2'b00, 5'd0,  32'h20,     32'h7,         32'h0};
        vecs[5]  = '{1'b1, 1'b0, 2'b10, 5'd6,  32'h20,     32'h0,         32'h7};
        vecs[6]  = '{1'b0, 1'b0, 2'b10, 5'd7,  32'h44,     32'hFFFF,      32'h0};
        vecs[7]  = '{1'b1, 1'b0, 2'b11, 5'd8,  32'h13,     32'h0,         32'hDEADBEEF};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h3FC,    32'h12345678,  32'h0};
        vecs[9]  = '{1'b1, 1'b0, 2'b01, 5'd9,  32'h7FC,    32'h0,         32'h12345678};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h30,     32'hAAAA0030,  32'h0};
        vecs[11] = '{1'b1, 1'b0, 2'b11, 5'd31, 32'h30,     32'h0,         32'hAAAA0030};

        br_tab[0] = 3'b000;
        br_tab[1] = 3'b010;
        br_tab[2] = 3'b100;
        br_tab[3] = 3'b111;

        // Reset acts without waiting for a clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_outputs", wb_now(), '0);
        check("rst_wbmux", W'(WB_mux_writedata), '0);
        check("rst_stall", W'(mem_stall), '0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            branch = br_tab[i][2];
            zero   = br_tab[i][1];
            #1;
            check($sformatf("pcsrc_b%0d_z%0d", br_tab[i][2], br_tab[i][1]),
                  W'(EX_MEM_PCSrc), W'(br_tab[i][0]));
        end
        branch = 1'b0;
        zero   = 1'b0;

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].rd_en, vecs[i].wr_en, vecs[i].wb, vecs[i].rdn, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rdata, $sformatf("vec%0d", i));
        end

        // Reset while outputs are live (and, with wait states, mid-store)
`ifdef MEM_WAIT_STATES_EN
        memread         = 1'b0;
        memwrite        = 1'b1;
        wb_ctl          = 2'b00;
        five_bit_muxout = 5'd0;
        alu_result      = 32'h30;
        rdata2          = 32'h9;
        @(posedge clk);
        #1;
        check("midwait_stall", W'(mem_stall), W'(1));
`endif
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", wb_now(), '0);
        check("async_rst_wbmux", W'(WB_mux_writedata), '0);
        check("async_rst_stall", W'(mem_stall), '0);
        @(posedge clk);
        #1;
        check("held_rst_outputs", wb_now(), '0);
        #2 rst = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        access(1'b1, 1'b0, 2'b11, 5'd2, 32'h30, 32'h0, 32'hAAAA0030, "post_rst_load");

        // Random store then load through a different aliased address
        for (int i = 0; i < 6; i++) begin
            int unsigned idx;
            logic [31:0] d;
            logic [31:0] a_st;
            logic [31:0] a_ld;
            idx  = $urandom_range(0, 255);
            d    = $urandom;
            a_st = 32'(($urandom_range(0, 15) << 10) | (idx << 2) | $urandom_range(0, 3));
            a_ld = 32'(($urandom_range(0, 15) << 10) | (idx << 2) | $urandom_range(0, 3));
            access(1'b0, 1'b1, 2'b00, 5'd0, a_st, d, 32'h0, $sformatf("rnd_st%0d", i));
            access(1'b1, 1'b0, 2'b11, 5'(i + 1), a_ld, 32'h0, d, $sformatf("rnd_ld%0d", i));
        end

        memread  = 1'b0;
        memwrite = 1'b0;
        @(posedge clk);
        #1;
        check("queue_drained", W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
